// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StFill,
    StWriteThru,
    StFlush
  } cache_state_e;

  localparam int unsigned StatsWidth = 16;

  function automatic int unsigned tag_bits(input int unsigned address_bits,
                                           input int unsigned index_bits,
                                           input int unsigned offset_bits);
    return address_bits - index_bits - offset_bits;
  endfunction

  function automatic int unsigned line_words(input int unsigned offset_bits);
    return 32'd1 << offset_bits;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side request bus, external memory bus and status lines of the cache controller.
interface cache_ctrl_if
  import cache_pkg::*;
#(
  parameter int unsigned BITS         = 16,
  parameter int unsigned ADDRESS_BITS = 16
) ();

  logic [ADDRESS_BITS-1:0] cpu_addr;
  logic [BITS-1:0]         cpu_din;
  logic [BITS-1:0]         cpu_dout;
  logic                    cpu_rd;
  logic                    cpu_wr;
  logic                    cpu_ready;
  logic                    flush;
  logic                    busy;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [BITS-1:0]         mem_din;
  logic [BITS-1:0]         mem_dout;
  logic                    mem_rd;
  logic                    mem_wr;
  logic                    mem_ack;
  logic [StatsWidth-1:0]   hit_count;
  logic [StatsWidth-1:0]   miss_count;

  // The cache controller.
  modport slave (
    input  cpu_addr, cpu_din, cpu_rd, cpu_wr, flush, mem_din, mem_ack,
    output cpu_dout, cpu_ready, busy, mem_addr, mem_dout, mem_rd, mem_wr,
    output hit_count, miss_count
  );

  // The environment: CPU requester plus external memory.
  modport master (
    output cpu_addr, cpu_din, cpu_rd, cpu_wr, flush, mem_din, mem_ack,
    input  cpu_dout, cpu_ready, busy, mem_addr, mem_dout, mem_rd, mem_wr,
    input  hit_count, miss_count
  );

endinterface

// File: rtl/cache_tag_store.sv
// Tag RAM plus per-line valid bits: one synchronous read port, one write port used for
// line allocation and for clearing lines during a flush sweep.
module cache_tag_store #(
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  clk_i,
  input  logic                  rd_en_i,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic                  rd_valid_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic                  wr_valid_i
);

  localparam int unsigned Lines = 1 << INDEX_BITS;

  logic [TAG_BITS-1:0] tag_mem [Lines];
  logic [Lines-1:0]    valid_mem;
  logic [TAG_BITS-1:0] rd_tag_q, rd_tag_d;
  logic                rd_valid_q, rd_valid_d;

  // Write-first: a read of the line being written returns the new contents, so the
  // lookup that follows a fill sees the freshly allocated tag.
  always_comb begin
    rd_tag_d   = rd_tag_q;
    rd_valid_d = rd_valid_q;
    if (rd_en_i) begin
      if (wr_en_i && (wr_index_i == rd_index_i)) begin
        rd_tag_d   = wr_tag_i;
        rd_valid_d = wr_valid_i;
      end else begin
        rd_tag_d   = tag_mem[rd_index_i];
        rd_valid_d = valid_mem[rd_index_i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_mem[wr_index_i]   <= wr_tag_i;
      valid_mem[wr_index_i] <= wr_valid_i;
    end
    rd_tag_q   <= rd_tag_d;
    rd_valid_q <= rd_valid_d;
  end

  assign rd_tag_o   = rd_tag_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with inline data RAM.
// Define CACHE_STATS_EN to build the saturating hit/miss counters; otherwise they read 0.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned BITS         = 16,
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned INDEX_BITS   = 6,
  parameter int unsigned OFFSET_BITS  = 2
) (
  input logic         CLK,
  input logic         RST,
  cache_ctrl_if.slave bus
);

  localparam int unsigned TagBits   = tag_bits(ADDRESS_BITS, INDEX_BITS, OFFSET_BITS);
  localparam int unsigned LineWords = line_words(OFFSET_BITS);
  localparam int unsigned DataAw    = INDEX_BITS + OFFSET_BITS;
  localparam int unsigned DataWords = 1 << DataAw;

  cache_state_e            state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0]         din_q, din_d;
  logic                    is_wr_q, is_wr_d;
  logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
  logic                    gap_q, gap_d;
  logic                    refill_q, refill_d;
  logic [INDEX_BITS-1:0]   sweep_q, sweep_d;
  logic                    flush_pend_q, flush_pend_d;

  logic [TagBits-1:0]    addr_tag;
  logic [INDEX_BITS-1:0] addr_index;
  assign addr_tag   = addr_q[ADDRESS_BITS-1 -: TagBits];
  assign addr_index = addr_q[OFFSET_BITS +: INDEX_BITS];

  // Shared read port control for tag store and data RAM.
  logic rd_en, rd_sel_cpu;

  logic [TagBits-1:0]    tag_rd_tag;
  logic                  tag_rd_valid;
  logic [INDEX_BITS-1:0] tag_rd_index;
  logic                  tag_we;
  logic [INDEX_BITS-1:0] tag_windex;
  logic                  tag_wvalid;

  logic                 data_we;
  logic [DataAw-1:0]    data_waddr;
  logic [BITS-1:0]      data_wdata;
  logic [DataAw-1:0]    data_raddr;
  logic [BITS-1:0]      data_mem [DataWords];
  logic [BITS-1:0]      data_rd_q, data_rd_d;

  logic                    hit;
  logic                    cpu_ready;
  logic                    mem_rd, mem_wr;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [BITS-1:0]         mem_dout;
  logic                    stat_hit, stat_miss, stat_clr;

  assign tag_rd_index = rd_sel_cpu ? bus.cpu_addr[OFFSET_BITS +: INDEX_BITS] : addr_index;
  assign data_raddr   = rd_sel_cpu ? bus.cpu_addr[DataAw-1:0] : addr_q[DataAw-1:0];
  assign hit          = tag_rd_valid && (tag_rd_tag == addr_tag);

  cache_tag_store #(
    .TAG_BITS   (TagBits),
    .INDEX_BITS (INDEX_BITS)
  ) u_tag_store (
    .clk_i      (CLK),
    .rd_en_i    (rd_en),
    .rd_index_i (tag_rd_index),
    .rd_tag_o   (tag_rd_tag),
    .rd_valid_o (tag_rd_valid),
    .wr_en_i    (tag_we),
    .wr_index_i (tag_windex),
    .wr_tag_i   (addr_tag),
    .wr_valid_i (tag_wvalid)
  );

  // Data RAM, write-first like the tag store.
  always_comb begin
    data_rd_d = data_rd_q;
    if (rd_en) begin
      data_rd_d = (data_we && (data_waddr == data_raddr)) ? data_wdata : data_mem[data_raddr];
    end
  end

  always_ff @(posedge CLK) begin
    if (data_we) begin
      data_mem[data_waddr] <= data_wdata;
    end
    data_rd_q <= data_rd_d;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    din_d        = din_q;
    is_wr_d      = is_wr_q;
    cnt_d        = cnt_q;
    gap_d        = 1'b0;
    refill_d     = refill_q;
    sweep_d      = sweep_q;
    flush_pend_d = flush_pend_q | bus.flush;
    rd_en        = 1'b0;
    rd_sel_cpu   = 1'b0;
    tag_we       = 1'b0;
    tag_windex   = addr_index;
    tag_wvalid   = 1'b1;
    data_we      = 1'b0;
    data_waddr   = addr_q[DataAw-1:0];
    data_wdata   = din_q;
    cpu_ready    = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_dout     = '0;
    stat_hit     = 1'b0;
    stat_miss    = 1'b0;
    stat_clr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.flush || flush_pend_q) begin
          state_d      = StFlush;
          sweep_d      = '0;
          flush_pend_d = 1'b0;
          stat_clr     = 1'b1;
        end else if (bus.cpu_rd || bus.cpu_wr) begin
          addr_d     = bus.cpu_addr;
          din_d      = bus.cpu_din;
          is_wr_d    = bus.cpu_wr;
          refill_d   = 1'b0;
          rd_en      = 1'b1;
          rd_sel_cpu = 1'b1;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        // The re-lookup after a fill belongs to the request already counted as a miss.
        if (!refill_q) begin
          stat_hit  = hit;
          stat_miss = !hit;
        end
        if (is_wr_q) begin
          data_we = hit;
          state_d = StWriteThru;
        end else if (hit) begin
          cpu_ready = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        mem_addr = {addr_q[ADDRESS_BITS-1:OFFSET_BITS], cnt_q};
        mem_rd   = !gap_q;
        if (!gap_q && bus.mem_ack) begin
          data_we    = 1'b1;
          data_waddr = {addr_index, cnt_q};
          data_wdata = bus.mem_din;
          cnt_d      = cnt_q + 1'b1;
          gap_d      = 1'b1;
          if (cnt_q == OFFSET_BITS'(LineWords - 1)) begin
            tag_we   = 1'b1;
            rd_en    = 1'b1;
            refill_d = 1'b1;
            state_d  = StLookup;
          end
        end
      end
      StWriteThru: begin
        mem_addr = addr_q;
        mem_dout = din_q;
        mem_wr   = 1'b1;
        if (bus.mem_ack) begin
          cpu_ready = 1'b1;
          state_d   = StIdle;
        end
      end
      StFlush: begin
        tag_we     = 1'b1;
        tag_windex = sweep_q;
        tag_wvalid = 1'b0;
        sweep_d    = sweep_q + 1'b1;
        if (sweep_q == {INDEX_BITS{1'b1}}) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StFlush;
      addr_q       <= '0;
      din_q        <= '0;
      is_wr_q      <= 1'b0;
      cnt_q        <= '0;
      gap_q        <= 1'b0;
      refill_q     <= 1'b0;
      sweep_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      is_wr_q      <= is_wr_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      refill_q     <= refill_d;
      sweep_q      <= sweep_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_dout  = (cpu_ready && !is_wr_q) ? data_rd_q : '0;
  assign bus.busy      = (state_q != StIdle);
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_dout  = mem_dout;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;

`ifdef CACHE_STATS_EN
  logic [StatsWidth-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stat_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (stat_hit && (hit_cnt_q != {StatsWidth{1'b1}})) begin
        hit_cnt_d = hit_cnt_q + 1'b1;
      end
      if (stat_miss && (miss_cnt_q != {StatsWidth{1'b1}})) begin
        miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats   = ^{stat_hit, stat_miss, stat_clr};
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed requests push expected read data, a monitor
// checks every cpu_ready strobe, and a memory model answers and logs bus traffic.
module tb_cache_ctrl;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cache_ctrl_if #(.BITS(16), .ADDRESS_BITS(16)) bus ();

  cache_ctrl #(
    .BITS         (16),
    .ADDRESS_BITS (16),
    .INDEX_BITS   (6),
    .OFFSET_BITS  (2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        wr;
    logic [15:0] data;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] bmem [logic [15:0]];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [15:0] rd_log[$];
  logic [15:0] wr_addr_l, wr_data_l;
  bit          stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mval(input logic [15:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a ^ 16'h5A5A;
  endfunction

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.cpu_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ready: got cpu_ready=1, expected no completion");
        end else begin
          e = exp_q.pop_front();
          if (!e.wr) check(e.name, 32'(bus.cpu_dout), 32'(e.data));
        end
      end
    end
  end

  // External memory: acknowledges one cycle after a strobe is seen, alternating.
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_din = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (!stall && !RST && (bus.mem_rd || bus.mem_wr)) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_rd) begin
          rd_cnt++;
          rd_log.push_back(bus.mem_addr);
          bus.mem_din = mval(bus.mem_addr);
        end else begin
          wr_cnt++;
          wr_addr_l = bus.mem_addr;
          wr_data_l = bus.mem_dout;
          bmem[bus.mem_addr] = bus.mem_dout;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] e, input string name);
    exp_t x;
    x = '{wr, e, name};
    exp_q.push_back(x);
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    bus.cpu_wr   = wr;
    bus.cpu_rd   = !wr;
  endtask

  // Latency counts the issuing cycle as 1.
  task automatic wait_ready(output int lat);
    lat = 1;
    while (1) begin
      @(negedge CLK);
      lat++;
      if (bus.cpu_ready === 1'b1) break;
      if (lat > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout: got no cpu_ready, expected one within 300 cycles");
        exp_q.delete();
        break;
      end
    end
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] e, input string name,
                        output int lat, output int drd, output int dwr);
    int r0, w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    rd_log.delete();
    issue(wr, a, d, e, name);
    wait_ready(lat);
    drd = rd_cnt - r0;
    dwr = wr_cnt - w0;
    @(negedge CLK);
  endtask

  task automatic busy_cycles(output int n, output int early);
    n = 0;
    early = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.busy !== 1'b1) return;
      n++;
      if (bus.cpu_ready === 1'b1) early++;
      @(negedge CLK);
    end
  endtask

  task automatic check_stats(input string name, input int h, input int m);
`ifdef CACHE_STATS_EN
    check({name, "_hits"}, 32'(bus.hit_count), h);
    check({name, "_misses"}, 32'(bus.miss_count), m);
`else
    check({name, "_hits_tied"}, 32'(bus.hit_count), 0);
    check({name, "_misses_tied"}, 32'(bus.miss_count), 0);
`endif
  endtask

  initial begin
    int lat, lat2, drd, dwr, bc, early, r0, found;
    RST          = 1'b1;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    bus.cpu_rd   = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.flush    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bmem[16'h1234 + 16'(i)] = 16'h00A0 + 16'(i);
      bmem[16'h5234 + 16'(i)] = 16'h00B0 + 16'(i);
    end
    repeat (3) @(negedge CLK);

    check("rst_busy", 32'(bus.busy), 1);
    check("rst_cpu_ready", 32'(bus.cpu_ready), 0);
    check("rst_mem_rd", 32'(bus.mem_rd), 0);
    check("rst_mem_wr", 32'(bus.mem_wr), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_cpu_dout", 32'(bus.cpu_dout), 0);
    check_stats("rst", 0, 0);

    // Read held across the post-reset sweep.
    rd_log.delete();
    r0 = rd_cnt;
    issue(1'b0, 16'h1234, 16'h0000, 16'h00A0, "rd_1234_cold");
    RST = 1'b0;
    busy_cycles(bc, early);
    check("sweep_len", bc, 64);
    check("no_ready_in_sweep", early, 0);
    wait_ready(lat);
    check("cold_fill_reads", rd_cnt - r0, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_log.size()) check("cold_fill_addr", 32'(rd_log[i]), 32'h1234 + 32'(i));
    end
    @(negedge CLK);

    do_req(1'b0, 16'h1236, 16'h0000, 16'h00A2, "rd_1236_hit", lat, drd, dwr);
    check("hit_mem_reads", drd, 0);
    check("hit_latency", lat, 2);

    do_req(1'b1, 16'h1235, 16'h5555, 16'h0000, "wr_1235", lat, drd, dwr);
    check("wt_mem_writes", dwr, 1);
    check("wt_mem_reads", drd, 0);
    check("wt_addr", 32'(wr_addr_l), 32'h1235);
    check("wt_data", 32'(wr_data_l), 32'h5555);

    do_req(1'b0, 16'h1235, 16'h0000, 16'h5555, "rd_1235_updated", lat, drd, dwr);
    check("upd_mem_reads", drd, 0);
    check("upd_latency", lat, 2);

    do_req(1'b1, 16'h8000, 16'h0777, 16'h0000, "wr_8000_noalloc", lat, drd, dwr);
    check("noalloc_writes", dwr, 1);
    check("noalloc_reads", drd, 0);
    check_stats("three_hits_two_misses", 3, 2);

    do_req(1'b0, 16'h8000, 16'h0000, 16'h0777, "rd_8000_miss", lat, drd, dwr);
    check("rd8000_reads", drd, 4);
    if (rd_log.size() > 0) check("rd8000_first_addr", 32'(rd_log[0]), 32'h8000);

    do_req(1'b0, 16'h5234, 16'h0000, 16'h00B0, "rd_5234_conflict", lat, drd, dwr);
    check("conflict_reads", drd, 4);
    if (rd_log.size() > 3) check("conflict_last_addr", 32'(rd_log[3]), 32'h5237);

    do_req(1'b0, 16'h1234, 16'h0000, 16'h00A0, "rd_1234_evicted", lat, drd, dwr);
    check("evicted_reads", drd, 4);
    check_stats("before_flush", 3, 5);

    // Flush pulse in IDLE.
    bus.flush = 1'b1;
    @(negedge CLK);
    bus.flush = 1'b0;
    busy_cycles(bc, early);
    check("flush_len", bc, 64);
    check_stats("after_flush", 0, 0);

    // Flush arriving mid-fill is held and serviced at the next IDLE.
    rd_log.delete();
    r0 = rd_cnt;
    issue(1'b0, 16'h1234, 16'h0000, 16'h00A0, "rd_1234_after_flush");
    fork
      wait_ready(lat2);
      begin
        repeat (3) @(negedge CLK);
        bus.flush = 1'b1;
        @(negedge CLK);
        bus.flush = 1'b0;
      end
    join
    check("post_flush_reads", rd_cnt - r0, 4);
    @(negedge CLK);
    check("idle_before_pending_flush", 32'(bus.busy), 0);
    @(negedge CLK);
    busy_cycles(bc, early);
    check("pending_flush_len", bc, 64);

    do_req(1'b0, 16'h1236, 16'h0000, 16'h00A2, "rd_1236_after_pend", lat, drd, dwr);
    check("after_pend_reads", drd, 4);
    check_stats("after_pend", 0, 1);
    do_req(1'b0, 16'h1237, 16'h0000, 16'h00A3, "rd_1237_hit", lat, drd, dwr);
    check("rd1237_reads", drd, 0);
    check_stats("final", 1, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset mid-fill aborts and drops strobes without waiting for a clock edge.
    stall = 1'b1;
    issue(1'b0, 16'h4000, 16'h0000, 16'h0000, "abort");
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (bus.mem_rd === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("abort_reached_fill", found, 1);
    #2 RST = 1'b1;
    #1;
    check("abort_mem_rd", 32'(bus.mem_rd), 0);
    check("abort_mem_addr", 32'(bus.mem_addr), 0);
    check("abort_busy", 32'(bus.busy), 1);
    check("abort_cpu_ready", 32'(bus.cpu_ready), 0);
    check_stats("abort", 0, 0);
    bus.cpu_rd = 1'b0;
    exp_q.delete();
    stall = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    busy_cycles(bc, early);
    check("resweep_len", bc, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate cache controller. Sits between a CPU-side word requester and the external memory bus. Owns the tag/valid store and the data store, and sequences lookup, line fill, write-through and invalidate sweeps. Provides the miss-handling sequencing the cache datapath needs.

Parameters:
BITS, 16, data word width
ADDRESS_BITS, 16, word address width (tag + index + offset)
INDEX_BITS, 6, line index width (64 lines)
OFFSET_BITS, 2, word-in-line width (4 words/line); TAG_BITS = ADDRESS_BITS-INDEX_BITS-OFFSET_BITS

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock; reset is asynchronous and active-high
cpu_addr  in  ADDRESS_BITS  request word address
cpu_din  in  BITS  write data
cpu_dout  out  BITS  read data, valid while cpu_ready=1 on a read
cpu_rd  in  1  read request, held until cpu_ready
cpu_wr  in  1  write request, held until cpu_ready (cpu_rd and cpu_wr never both high)
cpu_ready  out  1  one-cycle completion strobe
flush  in  1  invalidate-all request pulse
busy  out  1  high in any state other than IDLE
mem_addr  out  ADDRESS_BITS  external word address
mem_din  in  BITS  external read data, valid with mem_ack
mem_dout  out  BITS  external write data
mem_rd  out  1  external read strobe, held until mem_ack
mem_wr  out  1  external write strobe, held until mem_ack
mem_ack  in  1  external completion, one cycle
hit_count  out  16  hit counter (optional feature)
miss_count  out  16  miss counter (optional feature)

Behaviour:
- States: IDLE, LOOKUP, FILL, WRITE_THRU, FLUSH.
- Reset: state=FLUSH, sweep index=0, cpu_ready/mem_rd/mem_wr=0, mem_addr/mem_dout/cpu_dout=0, counters=0. Asserting RST mid-operation aborts it immediately; the strobes drop asynchronously.
- FLUSH: clears the valid bit of one index per cycle, 0..2^INDEX_BITS-1. Takes exactly 64 cycles at default parameters, then goes to IDLE. Requests are ignored but held by the requester.
- IDLE priority: flush > cpu_rd/cpu_wr. Accepting a request latches cpu_addr/cpu_din and issues synchronous tag and data RAM reads. Next state is LOOKUP.
- LOOKUP: hit = valid && tag match.
  - Read hit: cpu_ready=1 and cpu_dout=RAM word this cycle, then IDLE. Latency is 2 cycles from request sample to ready.
  - Read miss: go to FILL with word counter=0.
  - Write, hit or miss: if hit, write the data RAM word. Then WRITE_THRU. A miss does not allocate.
- FILL: mem_addr={tag,index,counter}, mem_rd=1.
  - On mem_ack: write mem_din to data RAM[index,counter] and drop mem_rd for one cycle.
  - counter wraps 3->0 only on the last word. Then write the tag, set valid, and return to LOOKUP, which re-reads and hits (no extra miss count).
- WRITE_THRU: mem_addr=latched addr, mem_dout=latched data, mem_wr=1. On mem_ack: cpu_ready=1, mem_wr=0, then IDLE.
- Requester drops cpu_rd/cpu_wr on the edge where cpu_ready=1, so IDLE never re-accepts it.
- A flush arriving outside IDLE is latched as pending and serviced at the next IDLE, ahead of any request.
- mem_ack outside FILL/WRITE_THRU is ignored.

Optional Feature:
CACHE_STATS_EN defined: hit_count/miss_count each increment once per LOOKUP outcome (a write counts by its hit/miss), saturate at 16'hFFFF, and clear on RST or flush acceptance.
Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Package cache_pkg: state enum, TAG_BITS/LINE_WORDS derivation functions, stats width constant.
- Sub-module cache_tag_store: tag RAM plus valid array, with a synchronous read port and a single write port for set, clear and flush sweep.
- The data RAM stays inline in cache_ctrl.

Test Plan:
- Release RST -> busy=1 for exactly 64 cycles, then IDLE; a cpu_rd held during the sweep completes only after it.
- Read 0x1234 cold, mem returns 0xA0..0xA3 for 0x1234..0x1237 -> 4 mem_rd at addresses 0x1234..0x1237, cpu_dout=0xA0. A second read of 0x1236 returns 0xA2 with 0 mem accesses, 2-cycle latency.
- Write 0x5555 to 0x1235 after that fill -> one mem_wr to 0x1235 with data 0x5555; a subsequent read of 0x1235 hits and returns 0x5555.
- Write to uncached 0x8000 -> mem_wr only, no mem_rd; a later read of 0x8000 misses and fills.
- Read 0x1234 then 0x5234 (same index, different tag) -> second is a miss that refills. A read of 0x1234 misses again.
- With CACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2. Pulse flush -> both 0 and the next read misses.
